// File: rtl/speed_pkg.sv
// rtl/speed_pkg.sv - shared FSM encoding and default constants for the wheel-speed unit
package speed_pkg;

   typedef enum logic [2:0] {
      IDLE,
      WAIT_FREE,
      ISSUE,
      WAIT_BUSY,
      WAIT_READY
   } state_t;

   localparam logic [15:0] CONST_DEFAULT     = 16'h49BA;
   localparam int          SPEED_MAX_DEFAULT = 99;

endpackage

// File: rtl/period_ring.sv
// rtl/period_ring.sv - ring of the last 2^AVG_LOG2 reed periods with running sum and fill count
module period_ring
   import speed_pkg::*;
#(
   parameter int CNT_W    = 16,
   parameter int AVG_LOG2 = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic             flush,
   input  logic [CNT_W-1:0] din,
   output logic [CNT_W-1:0] newest,
   output logic [CNT_W-1:0] avg,
   output logic             full,
   output logic             empty
);

   localparam int DEPTH = 1 << AVG_LOG2;
   localparam int SUM_W = CNT_W + AVG_LOG2;

   logic [CNT_W-1:0]    ring_q [DEPTH];
   logic [CNT_W-1:0]    ring_d [DEPTH];
   logic [AVG_LOG2-1:0] wr_ptr_q, wr_ptr_d;
   logic [AVG_LOG2-1:0] newest_ptr;
   logic [AVG_LOG2:0]   fill_q, fill_d;
   logic [SUM_W-1:0]    sum_q, sum_d;
   logic [CNT_W-1:0]    evicted;

   assign full       = (fill_q == (AVG_LOG2+1)'(DEPTH));
   assign empty      = (fill_q == '0);
   assign newest_ptr = wr_ptr_q - AVG_LOG2'(1);
   assign newest     = ring_q[newest_ptr];
   assign avg        = sum_q[SUM_W-1:AVG_LOG2];
   // Slots only contribute to the sum once the ring has filled since the last flush.
   assign evicted    = full ? ring_q[wr_ptr_q] : '0;

   always_comb begin
      ring_d   = ring_q;
      wr_ptr_d = wr_ptr_q;
      fill_d   = fill_q;
      sum_d    = sum_q;
      if (flush) begin
         fill_d = '0;
         sum_d  = '0;
      end else if (push) begin
         ring_d[wr_ptr_q] = din;
         wr_ptr_d         = wr_ptr_q + AVG_LOG2'(1);
         sum_d            = sum_q + SUM_W'(din) - SUM_W'(evicted);
         if (!full) fill_d = fill_q + (AVG_LOG2+1)'(1);
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < DEPTH; i++) ring_q[i] <= '0;
         wr_ptr_q <= '0;
         fill_q   <= '0;
         sum_q    <= '0;
      end else begin
         ring_q   <= ring_d;
         wr_ptr_q <= wr_ptr_d;
         fill_q   <= fill_d;
         sum_q    <= sum_d;
      end
   end

endmodule

// File: rtl/speed_avg.sv
// rtl/speed_avg.sv - wheel-speed unit: reed period counter, averaging ring and shared-divider request FSM
module speed_avg
   import speed_pkg::*;
#(
   parameter int          CNT_W     = 16,
   parameter int          CIRC_W    = 8,
   parameter int          SPEED_W   = 7,
   parameter logic [15:0] CONST     = CONST_DEFAULT,
   parameter int          AVG_LOG2  = 2,
   parameter int          SPEED_MAX = SPEED_MAX_DEFAULT
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               en,
   input  logic               reed,
   input  logic [CIRC_W-1:0]  circ,
   input  logic               avg_mode,
   input  logic               start,
   input  logic               clear_max,
   input  logic               div_busy,
   input  logic               div_ready,
   input  logic [CNT_W-1:0]   div_result,
   output logic               div_req,
   output logic [CNT_W-1:0]   div_dividend,
   output logic [CNT_W-1:0]   div_divisor,
   output logic [SPEED_W-1:0] speed,
   output logic               valid,
   output logic [SPEED_W-1:0] max_speed,
   output logic               stopped
);

   state_t               state_q, state_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;
   logic                 stopped_q, stopped_d;
   logic [SPEED_W-1:0]   speed_q, speed_d;
   logic                 valid_q, valid_d;
   logic [SPEED_W-1:0]   max_q, max_d;
   logic                 div_req_q, div_req_d;
   logic [CNT_W-1:0]     dividend_q, dividend_d;
   logic [CNT_W-1:0]     divisor_q, divisor_d;

   logic                 push, flush;
   logic [CNT_W-1:0]     ring_newest, ring_avg, period, dividend;
   logic                 ring_full, ring_empty;
   logic [CIRC_W+15:0]   product;
   logic                 speed_wr;
   logic [SPEED_W-1:0]   speed_new, speed_clamped;

   // A reed that ends a stationary spell carries a meaningless period, so it is not stored.
   assign push = en && reed && !stopped_q;

   period_ring #(
      .CNT_W    (CNT_W),
      .AVG_LOG2 (AVG_LOG2)
   ) u_ring (
      .clk    (clk),
      .rst    (rst),
      .push   (push),
      .flush  (flush),
      .din    (cnt_q),
      .newest (ring_newest),
      .avg    (ring_avg),
      .full   (ring_full),
      .empty  (ring_empty)
   );

   assign period        = ring_empty ? '0 : ((avg_mode && ring_full) ? ring_avg : ring_newest);
   assign product       = (CIRC_W+16)'(circ) * (CIRC_W+16)'(CONST);
   assign dividend      = CNT_W'(product >> 8);
   assign speed_clamped = (div_result > CNT_W'(SPEED_MAX)) ? SPEED_W'(SPEED_MAX)
                                                           : div_result[SPEED_W-1:0];

   always_comb begin
      cnt_d     = cnt_q;
      stopped_d = stopped_q;
      flush     = 1'b0;
      if (en) begin
         if (reed) begin
            cnt_d     = '0;
            stopped_d = 1'b0;
         end else begin
            if (cnt_q != '1) cnt_d = cnt_q + CNT_W'(1);
            if (cnt_d == '1) begin
               stopped_d = 1'b1;
               flush     = 1'b1;
            end
         end
      end
   end

   always_comb begin
      state_d    = state_q;
      valid_d    = valid_q;
      div_req_d  = 1'b0;
      dividend_d = dividend_q;
      divisor_d  = divisor_q;
      speed_wr   = 1'b0;
      speed_new  = '0;
      case (state_q)
         IDLE: begin
            if (start) begin
               valid_d = 1'b0;
               if (stopped_q || period == '0) begin
                  speed_wr = 1'b1;
                  valid_d  = 1'b1;
               end else begin
                  state_d = WAIT_FREE;
               end
            end
         end
         WAIT_FREE:  if (!div_busy) state_d = ISSUE;
         ISSUE: begin
            dividend_d = dividend;
            divisor_d  = period;
            div_req_d  = 1'b1;
            state_d    = WAIT_BUSY;
         end
         WAIT_BUSY:  if (div_busy) state_d = WAIT_READY;
         WAIT_READY: begin
            if (div_ready) begin
               speed_wr  = 1'b1;
               speed_new = speed_clamped;
               valid_d   = 1'b1;
               state_d   = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
      speed_d = speed_wr ? speed_new : speed_q;
      max_d   = max_q;
      if (speed_wr && (clear_max || speed_new > max_q)) max_d = speed_new;
      else if (clear_max)                                max_d = '0;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         stopped_q  <= 1'b0;
         speed_q    <= '0;
         valid_q    <= 1'b0;
         max_q      <= '0;
         div_req_q  <= 1'b0;
         dividend_q <= '0;
         divisor_q  <= '0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         stopped_q  <= stopped_d;
         speed_q    <= speed_d;
         valid_q    <= valid_d;
         max_q      <= max_d;
         div_req_q  <= div_req_d;
         dividend_q <= dividend_d;
         divisor_q  <= divisor_d;
      end
   end

   assign div_req      = div_req_q;
   assign div_dividend = dividend_q;
   assign div_divisor  = divisor_q;
   assign speed        = speed_q;
   assign valid        = valid_q;
   assign max_speed    = max_q;
   assign stopped      = stopped_q;

endmodule

// File: tb/tb_speed_avg.sv
// tb/tb_speed_avg.sv - self-checking bench for speed_avg with a queue-based period model and a divider responder
`timescale 1ns/1ps
module tb_speed_avg;

   localparam int DEPTH  = 4;
   localparam int CONSTV = 18874;

   logic        clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst, en, reed, avg_mode, start, clr_a;
   logic [7:0]  circ;
   logic        busy_f, busy_x, rdy_x;
   logic [15:0] res_x;
   logic        busy_m = 1'b0;
   logic        rdy_m  = 1'b0;
   logic        clr_b  = 1'b0;
   logic [15:0] res_m  = '0;
   logic        div_req;
   logic [15:0] div_dividend, div_divisor;
   logic [6:0]  speed, max_speed;
   logic        valid, stopped;
   logic        div_auto, clr_on_ready;
   int          div_lat;
   int          req_total = 0;
   int          checks = 0;
   int          failures = 0;

   speed_avg dut (
      .clk          (clk),
      .rst          (rst),
      .en           (en),
      .reed         (reed),
      .circ         (circ),
      .avg_mode     (avg_mode),
      .start        (start),
      .clear_max    (clr_a | clr_b),
      .div_busy     (busy_m | busy_f | busy_x),
      .div_ready    (rdy_m | rdy_x),
      .div_result   (rdy_x ? res_x : res_m),
      .div_req      (div_req),
      .div_dividend (div_dividend),
      .div_divisor  (div_divisor),
      .speed        (speed),
      .valid        (valid),
      .max_speed    (max_speed),
      .stopped      (stopped)
   );

   // Shared-divider responder: busy for div_lat cycles, then one ready pulse.
   always begin
      @(negedge clk);
      if (div_auto && div_req) begin
         busy_m = 1'b1;
         repeat (div_lat) @(negedge clk);
         busy_m = 1'b0;
         rdy_m  = 1'b1;
         res_m  = (div_divisor == 16'd0) ? 16'hFFFF : div_dividend / div_divisor;
         clr_b  = clr_on_ready;
         @(negedge clk);
         rdy_m  = 1'b0;
         clr_b  = 1'b0;
      end
   end

   always @(negedge clk) if (div_req) req_total++;

   // Reference model: history of accepted periods as a plain queue.
   int m_cnt;
   bit m_stop;
   int m_hist[$];
   int m_max;

   function automatic void m_reset();
      m_cnt  = 0;
      m_stop = 1'b0;
      m_hist.delete();
      m_max  = 0;
   endfunction

   function automatic void m_step(bit e, bit r);
      if (!e) return;
      if (r) begin
         if (m_stop) m_stop = 1'b0;
         else begin
            m_hist.push_back(m_cnt);
            if (m_hist.size() > DEPTH) void'(m_hist.pop_front());
         end
         m_cnt = 0;
      end else begin
         if (m_cnt < 65535) m_cnt++;
         if (m_cnt == 65535) begin
            m_stop = 1'b1;
            m_hist.delete();
         end
      end
   endfunction

   function automatic int m_period(bit am);
      int s = 0;
      if (m_hist.size() == 0) return 0;
      if (am && m_hist.size() == DEPTH) begin
         foreach (m_hist[i]) s += m_hist[i];
         return s / DEPTH;
      end
      return m_hist[m_hist.size()-1];
   endfunction

   function automatic int m_speed(int c, bit am);
      int p = m_period(am);
      int q;
      if (m_stop || p == 0) return 0;
      q = (((c * CONSTV) >> 8) % 65536) / p;
      return (q > 99) ? 99 : q;
   endfunction

   task automatic chk(string name, int act, int exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic cycle(bit e, bit r);
      en   = e;
      reed = r;
      @(negedge clk);
      m_step(e, r);
      en   = 1'b0;
      reed = 1'b0;
   endtask

   task automatic run_period(int p);
      repeat (p) cycle(1'b1, 1'b0);
      cycle(1'b1, 1'b1);
   endtask

   task automatic do_reset();
      rst = 1'b0; start = 1'b0; en = 1'b0; reed = 1'b0; clr_a = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b1;
      m_reset();
      @(negedge clk);
   endtask

   task automatic do_start(string name);
      int n = 0;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      while (!valid && n < 500) begin
         @(negedge clk);
         n++;
      end
      if (!valid) chk({name, "_timeout"}, 0, 1);
   endtask

   typedef struct {
      int p0, p1, p2, p3, np, am, c, dd, ds, sp;
   } vec_t;
   vec_t vecs[7];

   function automatic int vec_p(vec_t v, int k);
      case (k)
         0: return v.p0;
         1: return v.p1;
         2: return v.p2;
         default: return v.p3;
      endcase
   endfunction

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int r0, n, exp_sp;
      bit guard;
      vecs[0] = '{500,    0,    0,    0, 1, 0, 200, 14745,  500, 29};
      vecs[1] = '{400,  400,  600,  600, 4, 1, 200, 14745,  500, 29};
      vecs[2] = '{400,  600,  600,    0, 3, 1, 200, 14745,  600, 24};
      vecs[3] = '{100,    0,    0,    0, 1, 0, 200, 14745,  100, 99};
      vecs[4] = '{300,    0,    0,    0, 1, 0,  50,  3686,  300, 12};
      vecs[5] = '{1000, 1000, 1001, 1002, 4, 1, 255, 18800, 1000, 18};
      vecs[6] = '{400,  400,  600,  600, 4, 0, 200, 14745,  600, 24};

      div_auto = 1'b1; clr_on_ready = 1'b0; div_lat = 4;
      busy_f = 1'b0; busy_x = 1'b0; rdy_x = 1'b0; res_x = '0;
      circ = 8'd200; avg_mode = 1'b0;
      do_reset();
      chk("rst_speed",    int'(speed),        0);
      chk("rst_valid",    int'(valid),        0);
      chk("rst_max",      int'(max_speed),    0);
      chk("rst_stopped",  int'(stopped),      0);
      chk("rst_div_req",  int'(div_req),      0);
      chk("rst_dividend", int'(div_dividend), 0);
      chk("rst_divisor",  int'(div_divisor),  0);

      foreach (vecs[i]) begin
         do_reset();
         circ     = 8'(vecs[i].c);
         avg_mode = (vecs[i].am != 0);
         for (int k = 0; k < vecs[i].np; k++) run_period(vec_p(vecs[i], k));
         do_start($sformatf("vec%0d", i));
         chk($sformatf("vec%0d_dividend", i), int'(div_dividend), vecs[i].dd);
         chk($sformatf("vec%0d_divisor", i),  int'(div_divisor),  vecs[i].ds);
         chk($sformatf("vec%0d_speed", i),    int'(speed),        vecs[i].sp);
         chk($sformatf("vec%0d_valid", i),    int'(valid),        1);
         chk($sformatf("vec%0d_max", i),      int'(max_speed),    vecs[i].sp);
      end

      // clear_max coinciding with a speed write keeps the new speed
      do_reset(); circ = 8'd200; avg_mode = 1'b0;
      run_period(100);
      do_start("clamp");
      chk("clamp_max", int'(max_speed), 99);
      run_period(500);
      clr_on_ready = 1'b1;
      do_start("clr_same");
      clr_on_ready = 1'b0;
      chk("clr_same_max", int'(max_speed), 29);
      clr_a = 1'b1; @(negedge clk); clr_a = 1'b0;
      chk("clr_only_max", int'(max_speed), 0);
      chk("hold_speed",   int'(speed),     29);

      // divider busy holds off the launch; a start in WAIT_READY is ignored
      busy_f = 1'b1; div_lat = 8; r0 = req_total;
      start = 1'b1; @(negedge clk); start = 1'b0;
      repeat (20) @(negedge clk);
      chk("busy_no_req", req_total - r0, 0);
      chk("busy_valid",  int'(valid),    0);
      busy_f = 1'b0;
      n = 0;
      while (!busy_m && n < 50) begin @(negedge clk); n++; end
      repeat (3) @(negedge clk);
      start = 1'b1; @(negedge clk); start = 1'b0;
      n = 0;
      while (!valid && n < 100) begin @(negedge clk); n++; end
      repeat (20) @(negedge clk);
      chk("busy_one_req", req_total - r0, 1);
      chk("busy_speed",   int'(speed),    29);
      chk("busy_valid2",  int'(valid),    1);
      div_lat = 4;

      // stationary timeout, discarded first sample
      do_reset(); circ = 8'd200; avg_mode = 1'b0;
      repeat (65534) cycle(1'b1, 1'b0);
      chk("stop_early", int'(stopped), 0);
      cycle(1'b1, 1'b0);
      chk("stop_set", int'(stopped), 1);
      r0 = req_total;
      do_start("stop");
      chk("stop_speed", int'(speed), 0);
      chk("stop_valid", int'(valid), 1);
      run_period(300);
      chk("stop_clear", int'(stopped), 0);
      do_start("discard");
      chk("discard_speed", int'(speed), 0);
      chk("discard_noreq", req_total - r0, 0);
      run_period(500);
      do_start("after_stop");
      chk("after_stop_divisor", int'(div_divisor), 500);
      chk("after_stop_speed",   int'(speed),       29);

      // reset while waiting for the divider result
      do_reset(); circ = 8'd200; avg_mode = 1'b0;
      run_period(500);
      do_start("pre_rst");
      div_auto = 1'b0; r0 = req_total;
      start = 1'b1; @(negedge clk); start = 1'b0;
      n = 0;
      while (req_total == r0 && n < 50) begin @(negedge clk); n++; end
      chk("rst_txn_req", req_total - r0, 1);
      busy_x = 1'b1;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      #1;
      chk("arst_speed",    int'(speed),        0);
      chk("arst_max",      int'(max_speed),    0);
      chk("arst_divisor",  int'(div_divisor),  0);
      chk("arst_dividend", int'(div_dividend), 0);
      @(negedge clk);
      rst = 1'b1; busy_x = 1'b0; m_reset();
      @(negedge clk);
      res_x = 16'd20; rdy_x = 1'b1;
      @(negedge clk);
      rdy_x = 1'b0;
      repeat (5) @(negedge clk);
      chk("late_ready_valid", int'(valid),     0);
      chk("late_ready_speed", int'(speed),     0);
      chk("late_ready_max",   int'(max_speed), 0);
      div_auto = 1'b1;
      run_period(500);
      do_start("post_rst");
      chk("post_rst_speed", int'(speed), 29);

      // randomized activity against the reference model
      do_reset();
      for (int it = 0; it < 25; it++) begin
         circ     = 8'($urandom_range(0, 255));
         avg_mode = 1'($urandom_range(0, 1));
         div_lat  = $urandom_range(1, 6);
         n        = $urandom_range(20, 400);
         for (int k = 0; k < n; k++)
            cycle($urandom_range(0, 3) != 0, $urandom_range(0, 39) == 0);
         if ($urandom_range(0, 4) == 0) begin
            clr_a = 1'b1; @(negedge clk); clr_a = 1'b0;
            m_max = 0;
         end
         exp_sp = m_speed(int'(circ), avg_mode);
         guard  = m_stop || (m_period(avg_mode) == 0);
         r0     = req_total;
         do_start($sformatf("rnd%0d", it));
         chk($sformatf("rnd%0d_speed", it), int'(speed), exp_sp);
         chk($sformatf("rnd%0d_valid", it), int'(valid), 1);
         chk($sformatf("rnd%0d_req", it),   req_total - r0, guard ? 0 : 1);
         if (exp_sp > m_max) m_max = exp_sp;
         chk($sformatf("rnd%0d_max", it),   int'(max_speed), m_max);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
